register_bank: RTL

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits. Every register supports load, increment, decrement, clear and one-bit shifts, and the bank adds a registered carry/borrow flag, per-register zero flags and a combinational read port. It sits beside the control unit of the basic computer and supplies AR/PC/DR/AC/TR-style storage from one parametrised block instead of one hand-written register module per name. One operation executes per clock, on the register selected by `sel`.

---
 rtl/register_bank_pkg.sv | 17 +
 rtl/register_cell.sv | 66 ++++++
 rtl/register_bank.sv | 107 ++++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: op width and op encoding.
package register_bank_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_CLR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

endpackage

// File: rtl/register_cell.sv
// Combinational next-state logic for one register of the bank.
// The register itself lives in the top level; this cell only computes
// what the register would become and the carry it would produce.
module register_cell
    import register_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic             en,
    input  op_e              op,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_in,
    output logic [WIDTH-1:0] next_value,
    output logic             carry
);

    // Increment, either wrapping to zero or clamping at all-ones.
    function automatic logic [WIDTH-1:0] inc_value(input logic [WIDTH-1:0] v);
        if (&v) begin
            inc_value = (SATURATE != 0) ? v : '0;
        end else begin
            inc_value = v + WIDTH'(1);
        end
    endfunction

    // Decrement, either wrapping to all-ones or clamping at zero.
    function automatic logic [WIDTH-1:0] dec_value(input logic [WIDTH-1:0] v);
        if (v == '0) begin
            dec_value = (SATURATE != 0) ? v : '1;
        end else begin
            dec_value = v - WIDTH'(1);
        end
    endfunction

    // Next value and carry; a disabled cell holds and reports no carry.
    always_comb begin
        next_value = value;
        carry      = 1'b0;
        if (en) begin
            case (op)
                OP_LOAD: next_value = data_in;
                OP_INC: begin
                    next_value = inc_value(value);
                    carry      = &value;
                end
                OP_DEC: begin
                    next_value = dec_value(value);
                    carry      = (value == '0);
                end
                OP_CLR: next_value = '0;
                OP_SHL: begin
                    next_value = {value[WIDTH-2:0], shift_in};
                    carry      = value[WIDTH-1];
                end
                OP_SHR: begin
                    next_value = {shift_in, value[WIDTH-1:1]};
                    carry      = value[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS general-purpose registers with one op per clock on the
// register chosen by sel, a registered carry/borrow flag, an invalid-select
// error pulse, per-register zero flags and a combinational read port.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NUM_REGS    = 4,
    parameter int               SATURATE    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SEL_W       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear_all,
    input  logic [SEL_W-1:0]    sel,
    input  logic [OP_W-1:0]     op,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                shift_in,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [WIDTH-1:0]    rd_data,
    output logic [NUM_REGS-1:0] zero,
    output logic                carry_out,
    output logic                err
);

    logic [WIDTH-1:0]    regs      [NUM_REGS];
    logic [WIDTH-1:0]    next_regs [NUM_REGS];
    logic [NUM_REGS-1:0] sel_hit;
    logic [NUM_REGS-1:0] cell_carry;
    op_e                 op_code;
    logic                op_active;
    logic                carry_op;
    logic                sel_valid;

    assign op_code   = op_e'(op);
    assign sel_valid = |sel_hit;

    // Classify the op: does it do anything, and does it update the carry flag.
    always_comb begin
        op_active = 1'b0;
        carry_op  = 1'b0;
        case (op_code)
            OP_LOAD, OP_CLR:                op_active = 1'b1;
            OP_INC, OP_DEC, OP_SHL, OP_SHR: begin
                op_active = 1'b1;
                carry_op  = 1'b1;
            end
            default: ;
        endcase
    end

    // Decode per register; an out-of-range sel hits no cell at all.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign sel_hit[i] = (sel == SEL_W'(i));
        assign zero[i]    = (regs[i] == '0);

        register_cell #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_cell (
            .en         (sel_hit[i] & op_active),
            .op         (op_code),
            .value      (regs[i]),
            .data_in    (data_in),
            .shift_in   (shift_in),
            .next_value (next_regs[i]),
            .carry      (cell_carry[i])
        );
    end

    // Register storage; clear_all beats any op in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else if (clear_all) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= next_regs[i];
        end
    end

    // Carry flag from the selected cell, and one-cycle error on invalid sel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else if (clear_all) begin
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= op_active & ~sel_valid;
            if (carry_op && sel_valid) begin
                carry_out <= |cell_carry;
            end
        end
    end

    // Read port; out-of-range rd_sel reads as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_data = regs[i];
        end
    end

endmodule
